// File: rtl/vedic_mul16_seq.sv
// ----------------------------------------------------------------------------
// vedic_mul16_seq
//   Sequential 16x16 -> 32-bit multiplier that reuses a single combinational
//   vedic_8X8 core over four passes. Operands are split into 8-bit halves, each
//   partial product is shifted into place and accumulated, and the product is
//   returned with the tag of the request that produced it.
//
//   Ports
//     clk        in   clock, rising edge
//     rst        in   synchronous reset, active-high
//     in_valid   in   request valid
//     in_ready   out  request can be accepted this cycle
//     in_a       in   16-bit multiplicand
//     in_b       in   16-bit multiplier
//     in_tag     in   TAG_W request tag
//     in_signed  in   (VEDIC_SEQ_SIGNED_EN only) operands are two's complement
//     out_valid  out  result valid, held until out_ready
//     out_ready  in   consumer accepts result
//     out_p      out  32-bit product
//     out_tag    out  tag of the request that produced out_p
//     busy       out  high while multiplying or holding a result
//
//   Build option
//     VEDIC_SEQ_SIGNED_EN : adds in_signed and signed-magnitude handling.
//
//   Also contains the combinational core hierarchy vedic_2x2 -> vedic_4x4 ->
//   vedic_8X8 (Urdhva-Tiryagbhyam: four half-width products recombined).
// ----------------------------------------------------------------------------

module vedic_2x2 (
   input  logic [1:0] i_a,
   input  logic [1:0] i_b,
   output logic [3:0] o_p
);
   logic w_c1, w_c2, w_hi, w_carry;

   assign w_c1    = i_a[1] & i_b[0];
   assign w_c2    = i_a[0] & i_b[1];
   assign w_hi    = i_a[1] & i_b[1];
   // The two cross terms can both be 1; their carry feeds bit 2.
   assign w_carry = w_c1 & w_c2;
   assign o_p     = {w_hi & w_carry, w_hi ^ w_carry, w_c1 ^ w_c2, i_a[0] & i_b[0]};
endmodule

module vedic_4x4 (
   input  logic [3:0] i_a,
   input  logic [3:0] i_b,
   output logic [7:0] o_p
);
   logic [3:0] w_pp [4];

   // gi[0] selects the half of a, gi[1] the half of b.
   for (genvar gi = 0; gi < 4; gi++) begin : g_pp
      vedic_2x2 u_pp (
         .i_a (i_a[(gi % 2) * 2 +: 2]),
         .i_b (i_b[(gi / 2) * 2 +: 2]),
         .o_p (w_pp[gi])
      );
   end

   assign o_p = {4'b0, w_pp[0]} + {2'b0, w_pp[1], 2'b0}
              + {2'b0, w_pp[2], 2'b0} + {w_pp[3], 4'b0};
endmodule

module vedic_8X8 (
   input  logic [7:0]  i_a,
   input  logic [7:0]  i_b,
   output logic [15:0] o_p
);
   logic [7:0] w_pp [4];

   for (genvar gi = 0; gi < 4; gi++) begin : g_pp
      vedic_4x4 u_pp (
         .i_a (i_a[(gi % 2) * 4 +: 4]),
         .i_b (i_b[(gi / 2) * 4 +: 4]),
         .o_p (w_pp[gi])
      );
   end

   assign o_p = {8'b0, w_pp[0]} + {4'b0, w_pp[1], 4'b0}
              + {4'b0, w_pp[2], 4'b0} + {w_pp[3], 8'b0};
endmodule

module vedic_mul16_seq #(
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [15:0]      in_a,
   input  logic [15:0]      in_b,
   input  logic [TAG_W-1:0] in_tag,
`ifdef VEDIC_SEQ_SIGNED_EN
   input  logic             in_signed,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_p,
   output logic [TAG_W-1:0] out_tag,
   output logic             busy
);
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state, w_state_next;
   logic [1:0]       r_step;
   logic [15:0]      r_a, r_b;
   logic [TAG_W-1:0] r_tag;
   logic [31:0]      r_acc;

   logic             w_accept;
   logic [7:0]       w_core_a, w_core_b;
   logic [15:0]      w_pp;
   logic [1:0]       w_shift_bytes;
   logic [31:0]      w_pp_shifted;
   logic [31:0]      w_acc_sum;
   logic [31:0]      w_acc_next;
   logic [15:0]      w_a_mag, w_b_mag;

   // ------------------------------------------------------------------
   // Operand capture: magnitudes are taken at accept so the core always
   // multiplies unsigned values.
   // ------------------------------------------------------------------
`ifdef VEDIC_SEQ_SIGNED_EN
   logic w_a_neg, w_b_neg;
   logic r_neg;

   assign w_a_neg = in_signed & in_a[15];
   assign w_b_neg = in_signed & in_b[15];
   // -32768 negates to itself, which read unsigned is the correct magnitude.
   assign w_a_mag = w_a_neg ? (~in_a + 16'd1) : in_a;
   assign w_b_mag = w_b_neg ? (~in_b + 16'd1) : in_b;
`else
   assign w_a_mag = in_a;
   assign w_b_mag = in_b;
`endif

   // ------------------------------------------------------------------
   // Shared core: step[0] picks the high byte of a, step[1] the high byte
   // of b, so the shift is 8 bits per high byte selected.
   // ------------------------------------------------------------------
   assign w_core_a      = r_step[0] ? r_a[15:8] : r_a[7:0];
   assign w_core_b      = r_step[1] ? r_b[15:8] : r_b[7:0];
   assign w_shift_bytes = {r_step[1] & r_step[0], r_step[1] ^ r_step[0]};

   vedic_8X8 u_core (
      .i_a (w_core_a),
      .i_b (w_core_b),
      .o_p (w_pp)
   );

   assign w_pp_shifted = {16'b0, w_pp} << {w_shift_bytes, 3'b000};
   assign w_acc_sum    = r_acc + w_pp_shifted;

`ifdef VEDIC_SEQ_SIGNED_EN
   // Sign is applied on the last pass so the result is ready on entry to DONE.
   assign w_acc_next = (r_neg && r_step == 2'd3) ? (~w_acc_sum + 32'd1) : w_acc_sum;
`else
   assign w_acc_next = w_acc_sum;
`endif

   assign w_accept = in_valid & in_ready;

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // ------------------------------------------------------------------
   // FSM: next state and handshake outputs
   // ------------------------------------------------------------------
   always_comb begin
      w_state_next = r_state;
      in_ready     = 1'b0;
      out_valid    = 1'b0;
      busy         = 1'b0;
      case (r_state)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               w_state_next = S_MUL;
            end
         end
         S_MUL: begin
            busy = 1'b1;
            if (r_step == 2'd3) begin
               w_state_next = S_DONE;
            end
         end
         S_DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            // Result leaving frees the block for a request in the same cycle.
            in_ready  = out_ready;
            if (out_ready) begin
               w_state_next = in_valid ? S_MUL : S_IDLE;
            end
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
      if (rst) begin
         in_ready = 1'b0;
      end
   end

   // ------------------------------------------------------------------
   // Datapath registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_step <= 2'd0;
         r_a    <= 16'd0;
         r_b    <= 16'd0;
         r_tag  <= '0;
         r_acc  <= 32'd0;
`ifdef VEDIC_SEQ_SIGNED_EN
         r_neg  <= 1'b0;
`endif
      end else if (r_state == S_MUL) begin
         r_acc  <= w_acc_next;
         r_step <= r_step + 2'd1;
      end else if (w_accept) begin
         r_a    <= w_a_mag;
         r_b    <= w_b_mag;
         r_tag  <= in_tag;
         r_acc  <= 32'd0;
         r_step <= 2'd0;
`ifdef VEDIC_SEQ_SIGNED_EN
         r_neg  <= w_a_neg ^ w_b_neg;
`endif
      end
   end

   assign out_p   = r_acc;
   assign out_tag = r_tag;

endmodule
